// File: rtl/hazard_scoreboard_if.sv
// Hazard unit bundle: pipeline register addresses/controls in, forwarding
// selects and stall/flush controls out. The datapath owns the master side.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
    logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE, MemtoRegM;
    logic              BranchD, JumpD, start_multD, mfhiloD;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              StallF, StallD, FlushD, FlushE;
    logic              mult_busy;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, JumpD, start_multD, mfhiloD,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushD, FlushE, mult_busy, stall_count
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, JumpD, start_multD, mfhiloD,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushD, FlushE, mult_busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with forwarding, load-use/branch stalls, a HI/LO
// scoreboard for the multi-cycle mult/div unit and a registered jump squash.
// Optional stall-cycle counter is built only when HAZARD_PERF_EN is defined;
// otherwise stall_count is tied to zero.
module hazard_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam logic [7:0] LAT8 = 8'(MULT_LAT);

    logic [7:0] mult_cnt;
    logic       jflush;
    logic       lwstall, branchstall, multstall, anystall;
    logic       busy;

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst,
                                 input logic              we);
        return we && (src != '0) && (src == dst);
    endfunction

    // Forwarding selects: M stage has priority over W stage.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (hit(hz.rsE, hz.WriteRegM, hz.RegWriteM))      hz.ForwardAE = 2'b10;
        else if (hit(hz.rsE, hz.WriteRegW, hz.RegWriteW)) hz.ForwardAE = 2'b01;
        if (hit(hz.rtE, hz.WriteRegM, hz.RegWriteM))      hz.ForwardBE = 2'b10;
        else if (hit(hz.rtE, hz.WriteRegW, hz.RegWriteW)) hz.ForwardBE = 2'b01;
        hz.ForwardAD = hit(hz.rsD, hz.WriteRegM, hz.RegWriteM);
        hz.ForwardBD = hit(hz.rtD, hz.WriteRegM, hz.RegWriteM);
    end

    // Stall detection: load-use, branch operand not ready, mult/div busy.
    always_comb begin
        busy        = (mult_cnt != 8'd0);
        lwstall     = hz.MemtoRegE &&
                      (hit(hz.rsD, hz.WriteRegE, 1'b1) || hit(hz.rtD, hz.WriteRegE, 1'b1));
        branchstall = hz.BranchD &&
                      ((hz.RegWriteE &&
                        (hit(hz.rsD, hz.WriteRegE, 1'b1) || hit(hz.rtD, hz.WriteRegE, 1'b1))) ||
                       (hz.MemtoRegM &&
                        (hit(hz.rsD, hz.WriteRegM, 1'b1) || hit(hz.rtD, hz.WriteRegM, 1'b1))));
        multstall   = busy && (hz.start_multD || hz.mfhiloD);
        anystall    = lwstall || branchstall || multstall;
        hz.StallF    = anystall;
        hz.StallD    = anystall;
        hz.FlushE    = anystall;
        hz.FlushD    = jflush;
        hz.mult_busy = busy;
    end

    // Mult/div scoreboard: load latency on issue, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             mult_cnt <= '0;
        else if (hz.start_multD && !anystall)  mult_cnt <= LAT8;
        else if (mult_cnt != 8'd0)             mult_cnt <= mult_cnt - 8'd1;
    end

    // Jump squash: kill the wrong-path fetch once the jump leaves Decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) jflush <= 1'b0;
        else       jflush <= hz.JumpD && !anystall;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of stalled Decode cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               stall_cnt <= '0;
        else if (anystall && (stall_cnt != '1))  stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign hz.stall_count = stall_cnt;
`else
    assign hz.stall_count = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default-parameter instance and a small one
// (MULT_LAT=1, CNT_W=2) share the same stimulus. Checks come from a vector
// table, hand-written multi-cycle sequences and a randomized run compared
// against a cycle-index based reference model.
module tb_hazard_scoreboard;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(16)) ifm ();
    hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(2))  ifs ();

    assign ifs.rsD = ifm.rsD;             assign ifs.rtD = ifm.rtD;
    assign ifs.rsE = ifm.rsE;             assign ifs.rtE = ifm.rtE;
    assign ifs.WriteRegE = ifm.WriteRegE; assign ifs.WriteRegM = ifm.WriteRegM;
    assign ifs.WriteRegW = ifm.WriteRegW; assign ifs.RegWriteE = ifm.RegWriteE;
    assign ifs.RegWriteM = ifm.RegWriteM; assign ifs.RegWriteW = ifm.RegWriteW;
    assign ifs.MemtoRegE = ifm.MemtoRegE; assign ifs.MemtoRegM = ifm.MemtoRegM;
    assign ifs.BranchD = ifm.BranchD;     assign ifs.JumpD = ifm.JumpD;
    assign ifs.start_multD = ifm.start_multD;
    assign ifs.mfhiloD = ifm.mfhiloD;

    hazard_scoreboard #(.REG_AW(AW), .MULT_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hz(ifm.slave));
    hazard_scoreboard #(.REG_AW(AW), .MULT_LAT(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .hz(ifs.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the mult unit is free from cycle m_free[k] on.
    int cyc = 0;
    int m_free[2];
    bit m_jf[2];
    int m_cnt[2];
    int lat[2]  = '{4, 1};
    int cmax[2] = '{65535, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic we);
        return we && (s != 0) && (s == d);
    endfunction

    function automatic bit stall_of(input int k);
        bit lw, br, busy;
        lw = ifm.MemtoRegE && (hit(ifm.rsD, ifm.WriteRegE, 1) || hit(ifm.rtD, ifm.WriteRegE, 1));
        br = ifm.BranchD &&
             ((ifm.RegWriteE && (hit(ifm.rsD, ifm.WriteRegE, 1) || hit(ifm.rtD, ifm.WriteRegE, 1))) ||
              (ifm.MemtoRegM && (hit(ifm.rsD, ifm.WriteRegM, 1) || hit(ifm.rtD, ifm.WriteRegM, 1))));
        busy = cyc < m_free[k];
        return lw || br || (busy && (ifm.start_multD || ifm.mfhiloD));
    endfunction

    function automatic int fwd(input logic [AW-1:0] s);
        if (hit(s, ifm.WriteRegM, ifm.RegWriteM)) return 2;
        if (hit(s, ifm.WriteRegW, ifm.RegWriteW)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_free[k] = 0; m_jf[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic check_model();
        bit s0, s1;
        s0 = stall_of(0);
        s1 = stall_of(1);
        chk("ForwardAE", ifm.ForwardAE, fwd(ifm.rsE));
        chk("ForwardBE", ifm.ForwardBE, fwd(ifm.rtE));
        chk("ForwardAD", ifm.ForwardAD, hit(ifm.rsD, ifm.WriteRegM, ifm.RegWriteM));
        chk("ForwardBD", ifm.ForwardBD, hit(ifm.rtD, ifm.WriteRegM, ifm.RegWriteM));
        chk("StallF", ifm.StallF, s0);
        chk("StallD", ifm.StallD, s0);
        chk("FlushE", ifm.FlushE, s0);
        chk("FlushD", ifm.FlushD, m_jf[0]);
        chk("mult_busy", ifm.mult_busy, cyc < m_free[0]);
        chk("stall_count", ifm.stall_count, m_cnt[0]);
        chk("s_StallD", ifs.StallD, s1);
        chk("s_FlushD", ifs.FlushD, m_jf[1]);
        chk("s_mult_busy", ifs.mult_busy, cyc < m_free[1]);
        chk("s_stall_count", ifs.stall_count, m_cnt[1]);
    endtask

    // Advance one clock: inputs are stable across the rising edge.
    task automatic tick();
        bit st[2];
        bit j, s;
        st[0] = stall_of(0);
        st[1] = stall_of(1);
        j = ifm.JumpD;
        s = ifm.start_multD;
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (s && !st[k]) m_free[k] = cyc + 1 + lat[k];
                m_jf[k] = j && !st[k];
`ifdef HAZARD_PERF_EN
                if (st[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
`endif
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifm.rsD = 0; ifm.rtD = 0; ifm.rsE = 0; ifm.rtE = 0;
        ifm.WriteRegE = 0; ifm.WriteRegM = 0; ifm.WriteRegW = 0;
        ifm.RegWriteE = 0; ifm.RegWriteM = 0; ifm.RegWriteW = 0;
        ifm.MemtoRegE = 0; ifm.MemtoRegM = 0; ifm.BranchD = 0;
        ifm.JumpD = 0; ifm.start_multD = 0; ifm.mfhiloD = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] rsD, rtD, rsE, rtE, we, wm, ww;
        logic rwe, rwm, rww, mre, mrm, br;
        int fae, fbe, fad, fbd, st;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //         rsD rtD rsE rtE WE WM WW rwe rwm rww mre mrm br  fae fbe fad fbd st
        vecs[0]  = '{0, 0, 3, 0, 0, 3, 3, 0, 1, 1, 0, 0, 0,  2, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 3, 3, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 6, 0, 6, 6, 0, 1, 1, 0, 0, 0,  0, 2, 0, 0, 0};
        vecs[4]  = '{0, 9, 0, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0};
        vecs[5]  = '{0, 8, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1};
        vecs[6]  = '{0, 8, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[7]  = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1};
        vecs[8]  = '{5, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1,  0, 0, 1, 0, 1};
        vecs[9]  = '{5, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0};
        vecs[10] = '{0, 7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0};
        vecs[12] = '{5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[13] = '{0, 4, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1};

        reset = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state with all inputs idle.
        chk("rst_ForwardAE", ifm.ForwardAE, 0);
        chk("rst_ForwardBE", ifm.ForwardBE, 0);
        chk("rst_StallD", ifm.StallD, 0);
        chk("rst_FlushD", ifm.FlushD, 0);
        chk("rst_mult_busy", ifm.mult_busy, 0);
        chk("rst_stall_count", ifm.stall_count, 0);

        // Vector table: forwarding and stall conditions with the mult unit idle.
        foreach (vecs[i]) begin
            ifm.rsD = vecs[i].rsD; ifm.rtD = vecs[i].rtD;
            ifm.rsE = vecs[i].rsE; ifm.rtE = vecs[i].rtE;
            ifm.WriteRegE = vecs[i].we; ifm.WriteRegM = vecs[i].wm; ifm.WriteRegW = vecs[i].ww;
            ifm.RegWriteE = vecs[i].rwe; ifm.RegWriteM = vecs[i].rwm; ifm.RegWriteW = vecs[i].rww;
            ifm.MemtoRegE = vecs[i].mre; ifm.MemtoRegM = vecs[i].mrm; ifm.BranchD = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_ForwardAE", i), ifm.ForwardAE, vecs[i].fae);
            chk($sformatf("vec%0d_ForwardBE", i), ifm.ForwardBE, vecs[i].fbe);
            chk($sformatf("vec%0d_ForwardAD", i), ifm.ForwardAD, vecs[i].fad);
            chk($sformatf("vec%0d_ForwardBD", i), ifm.ForwardBD, vecs[i].fbd);
            chk($sformatf("vec%0d_StallF", i), ifm.StallF, vecs[i].st);
            chk($sformatf("vec%0d_StallD", i), ifm.StallD, vecs[i].st);
            chk($sformatf("vec%0d_FlushE", i), ifm.FlushE, vecs[i].st);
            check_model();
            tick();
        end

        // Mult scoreboard, MULT_LAT=4: issue at c0, second mult waits until c5.
        idle_inputs();
        tick();
        ifm.start_multD = 1; #1;
        chk("mul_c0_stall", ifm.StallD, 0); check_model(); tick();
        ifm.start_multD = 0; #1;
        chk("mul_c1_busy", ifm.mult_busy, 1); check_model(); tick();
        for (int c = 2; c <= 4; c++) begin
            ifm.start_multD = 1; #1;
            chk($sformatf("mul_c%0d_busy", c), ifm.mult_busy, 1);
            chk($sformatf("mul_c%0d_stall", c), ifm.StallD, 1);
            check_model(); tick();
        end
        #1;
        chk("mul_c5_busy", ifm.mult_busy, 0);
        chk("mul_c5_stall", ifm.StallD, 0);
        check_model(); tick();
        ifm.start_multD = 0; ifm.mfhiloD = 1; #1;
        chk("mul_c6_busy", ifm.mult_busy, 1);
        chk("mfhilo_stall", ifm.StallD, 1);
        check_model(); tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin #1; check_model(); tick(); end
        #1;
        chk("mul_drained", ifm.mult_busy, 0);

        // Jump without stall: FlushD exactly one cycle later.
        ifm.JumpD = 1; #1;
        chk("jmp_c0_flushD", ifm.FlushD, 0); check_model(); tick();
        ifm.JumpD = 0; #1;
        chk("jmp_c1_flushD", ifm.FlushD, 1); check_model(); tick();
        #1;
        chk("jmp_c2_flushD", ifm.FlushD, 0); check_model(); tick();

        // Jump held by load-use stall; stall right after the squash keeps FlushD.
        ifm.JumpD = 1; ifm.MemtoRegE = 1; ifm.WriteRegE = 8; ifm.rtD = 8; #1;
        chk("jmpst_c0_stall", ifm.StallD, 1);
        chk("jmpst_c0_flushD", ifm.FlushD, 0); check_model(); tick();
        ifm.MemtoRegE = 0; #1;
        chk("jmpst_c1_flushD", ifm.FlushD, 0); check_model(); tick();
        ifm.JumpD = 0; ifm.MemtoRegE = 1; #1;
        chk("jmpst_c2_flushD", ifm.FlushD, 1);
        chk("jmpst_c2_stall", ifm.StallD, 1); check_model(); tick();
        idle_inputs(); #1; check_model(); tick();

        // Saturation and asynchronous reset in the middle of a mult.
        do_reset();
        ifm.MemtoRegE = 1; ifm.WriteRegE = 8; ifm.rtD = 8;
        for (int c = 0; c < 5; c++) begin #1; check_model(); tick(); end
`ifdef HAZARD_PERF_EN
        chk("sat_small_cnt", ifs.stall_count, 3);
        chk("cnt5_main", ifm.stall_count, 5);
`else
        chk("cnt_tied_small", ifs.stall_count, 0);
        chk("cnt_tied_main", ifm.stall_count, 0);
`endif
        for (int c = 0; c < 2; c++) begin #1; check_model(); tick(); end
        idle_inputs();
        ifm.start_multD = 1; #1; check_model(); tick();
        ifm.start_multD = 0; #1; check_model(); tick();
        #1; check_model();
        chk("pre_rst_busy", ifm.mult_busy, 1);
`ifdef HAZARD_PERF_EN
        chk("pre_rst_cnt", ifm.stall_count, 7);
`endif
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_busy", ifm.mult_busy, 0);
        chk("async_rst_cnt", ifm.stall_count, 0);
        chk("async_rst_s_cnt", ifs.stall_count, 0);
        tick();
        reset = 1'b0;
        #1; check_model(); tick();

        // Randomized run against the reference model.
        for (int n = 0; n < 400; n++) begin
            ifm.rsD = AW'($urandom_range(0, 7)); ifm.rtD = AW'($urandom_range(0, 7));
            ifm.rsE = AW'($urandom_range(0, 7)); ifm.rtE = AW'($urandom_range(0, 7));
            ifm.WriteRegE = AW'($urandom_range(0, 7));
            ifm.WriteRegM = AW'($urandom_range(0, 7));
            ifm.WriteRegW = AW'($urandom_range(0, 7));
            ifm.RegWriteE = 1'($urandom); ifm.RegWriteM = 1'($urandom);
            ifm.RegWriteW = 1'($urandom);
            ifm.MemtoRegE = ($urandom_range(0, 3) == 0);
            ifm.MemtoRegM = ($urandom_range(0, 3) == 0);
            ifm.BranchD   = ($urandom_range(0, 3) == 0);
            ifm.JumpD     = ($urandom_range(0, 4) == 0);
            ifm.start_multD = ($urandom_range(0, 5) == 0);
            ifm.mfhiloD     = ($urandom_range(0, 7) == 0);
            #1;
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
